col_parity_stream: RTL and testbench

- Parametrised successor to the column-parity datapath; computes the Keccak theta column-parity mix on a state of DEPTH slices of 25 bits.
- Processes a whole slice per cycle over valid/ready streams instead of bit-serial file I/O.
- Buffers a full frame so slice 0 correctly uses the parity of slice DEPTH-1 (true z wrap-around).
- Sits between the state loader and the next round-step block.

---
 rtl/colpar_pkg.sv | 30 +++
 rtl/col_parity_stream_theta_slice_mix.sv | 21 ++
 rtl/col_parity_stream.sv | 136 +++++++++++++
 tb/tb_col_parity_stream.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/colpar_pkg.sv
// Shared types and helpers for the column-parity (Keccak theta) stream block.
// Bit map of a slice: bit i = 5*y + x, x = column, y = row.
package colpar_pkg;

  localparam int SLICE_W = 25;
  localparam int ROWS    = 5;
  localparam int COLS    = 5;

  typedef logic [SLICE_W-1:0] slice_t;
  typedef logic [COLS-1:0]    colpar_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Column parity of one slice: C[x] = XOR over all rows y of A[x,y].
  function automatic colpar_t col_parity(input slice_t s);
    colpar_t c;
    c = '0;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        c[x] = c[x] ^ s[COLS*y + x];
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/col_parity_stream_theta_slice_mix.sv
// Combinational theta mix of one slice:
//   out[x,y] = A[x,y] ^ cur_par[(x+4)%5] ^ prev_par[(x+1)%5]
// cur_par is the column parity of this slice, prev_par that of slice z-1.
module theta_slice_mix
  import colpar_pkg::*;
(
  input  slice_t  slice,
  input  colpar_t cur_par,
  input  colpar_t prev_par,
  output slice_t  mixed
);

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    for (genvar gj = 0; gj < ROWS; gj++) begin : g_row
      assign mixed[COLS*gj + gi] = slice[COLS*gj + gi]
                                 ^ cur_par[(gi + COLS - 1) % COLS]
                                 ^ prev_par[(gi + 1) % COLS];
    end
  end

endmodule

// File: rtl/col_parity_stream.sv
// Frame-buffered Keccak theta column-parity mix, one 25-bit slice per cycle.
// A whole frame of DEPTH slices is loaded first so that slice 0 can use the
// parity of slice DEPTH-1 (true z wrap-around), then the frame is emitted in
// order z = 0..DEPTH-1. Frames do not overlap.
// Optional build macro COLPAR_PARITY_OUT_EN adds port par_out[4:0], the column
// parity of the slice currently presented on out_data.
module col_parity_stream
  import colpar_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [24:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_data,
  output logic        out_last,
  output logic        busy
`ifdef COLPAR_PARITY_OUT_EN
  ,
  output logic [4:0]  par_out
`endif
);

  localparam int            CW   = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  // Frame buffer; contents are don't-care after reset.
  slice_t frame_mem [DEPTH];

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  colpar_t       prev_par_reg, prev_par_next;

  slice_t  cur_slice;
  slice_t  mixed;
  colpar_t cur_par;
  colpar_t in_par;
  logic    in_fire;
  logic    out_fire;
  logic    at_last;

  // Input is accepted in IDLE/LOAD; held off while reset is asserted.
  assign in_ready  = rst && (state_reg != EMIT);
  assign out_valid = (state_reg == EMIT);
  assign busy      = (state_reg != IDLE);

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign at_last   = (count_reg == LAST);

  assign cur_slice = frame_mem[count_reg];
  assign cur_par   = col_parity(cur_slice);
  assign in_par    = col_parity(in_data);

  theta_slice_mix u_mix (
    .slice    (cur_slice),
    .cur_par  (cur_par),
    .prev_par (prev_par_reg),
    .mixed    (mixed)
  );

  // Output data is forced to zero whenever it is not valid.
  assign out_data = out_valid ? mixed : '0;
  assign out_last = out_valid && at_last;

`ifdef COLPAR_PARITY_OUT_EN
  assign par_out  = out_valid ? cur_par : '0;
`endif

  // Frame buffer write; in IDLE the counter is 0 so slice 0 lands in entry 0.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      frame_mem[count_reg] <= in_data;
    end
  end

  // State, slice counter and previous-slice parity registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      prev_par_reg <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      prev_par_reg <= prev_par_next;
    end
  end

  // Next-state logic: IDLE -> LOAD -> EMIT -> IDLE.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    prev_par_next = prev_par_reg;
    case (state_reg)
      IDLE: begin
        if (in_fire) begin
          count_next = CW'(1);
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (in_fire) begin
          if (at_last) begin
            // Parity of slice DEPTH-1 seeds the mix of slice 0.
            prev_par_next = in_par;
            count_next    = '0;
            state_next    = EMIT;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
      end
      EMIT: begin
        if (out_fire) begin
          prev_par_next = cur_par;
          if (at_last) begin
            count_next = '0;
            state_next = IDLE;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_col_parity_stream.sv
// Self-checking bench for col_parity_stream with DEPTH=4: directed frame table,
// randomized frames with gaps/backpressure against a theta reference model,
// and a reset-mid-frame sequence.
module tb_col_parity_stream;

  localparam int D = 4;

  typedef logic [0:D-1][24:0] frame_t;

  typedef struct {
    string  name;
    frame_t din;
    frame_t dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [24:0] out_data;
  logic        out_last;
  logic        busy;
`ifdef COLPAR_PARITY_OUT_EN
  logic [4:0]  par_out;
`endif

  int checks   = 0;
  int failures = 0;

  col_parity_stream #(.DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
`ifdef COLPAR_PARITY_OUT_EN
    ,
    .par_out   (par_out)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Column parity of each slice straight from the definition C[x][z].
  task automatic parity_of(input frame_t a, input int z, output logic [4:0] c);
    c = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        c[x] = c[x] ^ a[z][5*y + x];
  endtask

  // Reference theta: out[x,y,z] = A ^ C[(x+4)%5][z] ^ C[(x+1)%5][(z+D-1)%D].
  task automatic theta_model(input frame_t a, output frame_t o);
    logic [4:0] c [D];
    for (int z = 0; z < D; z++) parity_of(a, z, c[z]);
    o = '0;
    for (int z = 0; z < D; z++)
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          o[z][5*y + x] = a[z][5*y + x] ^ c[z][(x + 4) % 5] ^ c[(z + D - 1) % D][(x + 1) % 5];
  endtask

  // Feed one frame; optional random input gaps. No output may appear while loading.
  task automatic send_frame(input frame_t f, input bit gaps);
    int  z = 0;
    int  guard = 0;
    bit  fire;
    while (z < D) begin
      @(negedge clk);
      check("no_early_out", {31'd0, out_valid}, 32'd0);
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 25'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = f[z];
      end
      fire = in_valid && in_ready;
      @(posedge clk);
      if (fire) z++;
      guard++;
      if (guard > 100) begin
        check("in_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  // Drain one frame and compare; optional random out_ready and junk input during EMIT.
  task automatic collect(input string tag, input frame_t din, input frame_t exp,
                         input bit toggle, input bit junk);
    int          z = 0;
    int          guard = 0;
    bit          stalled = 1'b0;
    logic [24:0] held = '0;
`ifdef COLPAR_PARITY_OUT_EN
    logic [4:0]  pexp;
`endif
    while (z < D) begin
      @(negedge clk);
      if (guard == 0) check({tag, "_latency"}, {31'd0, out_valid}, 32'd1);
      out_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (junk) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 25'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        $display("%s z=%0d out_data=%h out_last=%0b out_ready=%0b", tag, z, out_data, out_last, out_ready);
        check({tag, "_data"}, {7'd0, out_data}, {7'd0, exp[z]});
        check({tag, "_last"}, {31'd0, out_last}, {31'd0, (z == D - 1)});
        check({tag, "_in_ready_emit"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_busy_emit"}, {31'd0, busy}, 32'd1);
        if (stalled) check({tag, "_stall_stable"}, {7'd0, out_data}, {7'd0, held});
`ifdef COLPAR_PARITY_OUT_EN
        parity_of(din, z, pexp);
        check({tag, "_par_out"}, {27'd0, par_out}, {27'd0, pexp});
`endif
        stalled = !out_ready;
        held    = out_data;
        if (out_ready) z++;
      end
      guard++;
      if (guard > 100) begin
        check({tag, "_out_timeout"}, 32'd0, 32'd1);
        break;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_data"}, {7'd0, out_data}, 32'd0);
`ifdef COLPAR_PARITY_OUT_EN
    check({tag, "_idle_par"}, {27'd0, par_out}, 32'd0);
`endif
  endtask

  vec_t   vecs [5];
  frame_t rnd_in;
  frame_t rnd_exp;
  frame_t ones;

  initial begin
    // Directed frames with hand-derived expected outputs.
    vecs[0].name = "zero";
    vecs[0].din  = '{25'h0, 25'h0, 25'h0, 25'h0};
    vecs[0].dout = '{25'h0, 25'h0, 25'h0, 25'h0};
    vecs[1].name = "z0_bit0";
    vecs[1].din  = '{25'h0000001, 25'h0, 25'h0, 25'h0};
    vecs[1].dout = '{25'h0210843, 25'h1084210, 25'h0, 25'h0};
    vecs[2].name = "wrap_z3";
    vecs[2].din  = '{25'h0, 25'h0, 25'h0, 25'h0000001};
    vecs[2].dout = '{25'h1084210, 25'h0, 25'h0, 25'h0210843};
    vecs[3].name = "z1_bit0";
    vecs[3].din  = '{25'h0, 25'h0000001, 25'h0, 25'h0};
    vecs[3].dout = '{25'h0, 25'h0210843, 25'h1084210, 25'h0};
    vecs[4].name = "all_ones";
    vecs[4].din  = '{25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF};
    vecs[4].dout = '{25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF};
    ones         = vecs[4].din;

    // Reset state while reset is held.
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_data", {7'd0, out_data}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven directed frames.
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].din, 1'b0);
      collect(vecs[i].name, vecs[i].din, vecs[i].dout, 1'b0, 1'b0);
    end

    // Randomized frames against the reference model, gaps and backpressure.
    for (int n = 0; n < 20; n++) begin
      for (int z = 0; z < D; z++) rnd_in[z] = 25'($urandom);
      theta_model(rnd_in, rnd_exp);
      send_frame(rnd_in, 1'b1);
      collect("rand", rnd_in, rnd_exp, 1'b1, 1'b1);
    end

    // Reset after two of four input slices; partial frame must vanish.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 25'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mid_no_output", {31'd0, out_valid}, 32'd0);
    end
    send_frame(ones, 1'b0);
    collect("after_rst", ones, ones, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
